piso_shift_register: RTL and testbench



---
 rtl/piso_shift_register_pkg.sv | 7 +
 rtl/piso_stage.sv | 27 ++
 rtl/piso_shift_register.sv | 43 ++++
 tb/tb_piso_shift_register.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/piso_shift_register_pkg.sv
// Shared encodings for the PISO shift register's mode select.
package piso_shift_register_pkg;

  localparam logic PISO_LOAD  = 1'b0;
  localparam logic PISO_SHIFT = 1'b1;

endpackage

// File: rtl/piso_stage.sv
// One bit cell of the PISO register: load/shift mux feeding a D flop with synchronous clear.
module piso_stage
  import piso_shift_register_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic sel,
  input  logic load_d,
  input  logic shift_d,
  output logic q
);

  logic r_q;
  logic w_d;

  always_comb begin
    w_d = (sel == PISO_SHIFT) ? shift_d : load_d;
  end

  always_ff @(posedge clk) begin
    if (clr) r_q <= 1'b0;
    else     r_q <= w_d;
  end

  assign q = r_q;

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out shift register: load a WIDTH-bit word, shift it out LSB first on so.
module piso_shift_register
  import piso_shift_register_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter logic        FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] pi,
  input  logic             sel,
  output logic             so
);

  if (WIDTH < 2) begin : g_width_check
    $error("piso_shift_register: WIDTH must be >= 2");
  end

  logic [WIDTH-1:0] w_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic w_shift_d;

    // The MSB stage has no neighbour above it; it shifts in FILL.
    if (i == WIDTH - 1) begin : g_top
      assign w_shift_d = FILL;
    end else begin : g_mid
      assign w_shift_d = w_q[i+1];
    end

    piso_stage u_stage (
      .clk     (clk),
      .clr     (clr),
      .sel     (sel),
      .load_d  (pi[i]),
      .shift_d (w_shift_d),
      .q       (w_q[i])
    );
  end

  assign so = w_q[0];

endmodule

// File: tb/tb_piso_shift_register.sv
// Bench for piso_shift_register: directed vector table, hand sequences and a queue-based random model.
module tb_piso_shift_register;

  logic       clk = 1'b0;
  logic       clr4, sel4, so4;
  logic [3:0] pi4;
  logic       clr8, sel8, so8;
  logic [7:0] pi8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  piso_shift_register #(.WIDTH(4), .FILL(1'b0)) dut4 (
    .clk (clk), .clr (clr4), .pi (pi4), .sel (sel4), .so (so4)
  );

  piso_shift_register #(.WIDTH(8), .FILL(1'b1)) dut8 (
    .clk (clk), .clr (clr8), .pi (pi8), .sel (sel8), .so (so8)
  );

  typedef struct {
    logic       clr;
    logic       sel;
    logic [3:0] pi;
    logic       so;
    logic       chk_q;
    logic [3:0] q;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step4(input logic c, input logic s, input logic [3:0] p);
    clr4 = c; sel4 = s; pi4 = p;
    @(posedge clk); #1;
  endtask

  task automatic step8(input logic c, input logic s, input logic [7:0] p);
    clr8 = c; sel8 = s; pi8 = p;
    @(posedge clk); #1;
  endtask

  initial begin
    bit          mq[$];
    logic        c, s;
    logic [7:0]  p;
    logic [7:0]  w8;
    logic [7:0]  exp8[11];

    clr4 = 1'b1; sel4 = 1'b0; pi4 = '0;
    clr8 = 1'b1; sel8 = 1'b0; pi8 = '0;

    // Directed 4-bit vectors: reset, load/shift, back-to-back, interrupt, clear priority.
    tbl[0]  = '{1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 4'h0};
    tbl[1]  = '{1'b0, 1'b0, 4'hE, 1'b0, 1'b0, 4'h0};
    tbl[2]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 4'h0};
    tbl[3]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 4'h0};
    tbl[4]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 4'h0};
    tbl[5]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 4'h0};
    tbl[6]  = '{1'b0, 1'b0, 4'h6, 1'b0, 1'b0, 4'h0};
    tbl[7]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 4'h0};
    tbl[8]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 4'h0};
    tbl[9]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0};
    tbl[10] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 4'h0};
    tbl[11] = '{1'b0, 1'b0, 4'hA, 1'b0, 1'b0, 4'h0};
    tbl[12] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 4'h0};
    tbl[13] = '{1'b0, 1'b0, 4'h5, 1'b1, 1'b1, 4'h5};
    tbl[14] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 4'h2};
    tbl[15] = '{1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 4'h0};
    tbl[16] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 4'h0};
    tbl[17] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 4'h0};
    tbl[18] = '{1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 4'h0};
    tbl[19] = '{1'b0, 1'b0, 4'h3, 1'b1, 1'b1, 4'h3};

    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      step4(tbl[i].clr, tbl[i].sel, tbl[i].pi);
      chk($sformatf("vec%0d_so", i), 32'(so4), 32'(tbl[i].so));
      if (tbl[i].chk_q) chk($sformatf("vec%0d_q", i), 32'(dut4.w_q), 32'(tbl[i].q));
    end

    // pi/sel wiggling between edges must not disturb so.
    step4(1'b0, 1'b0, 4'h1);
    chk("load_1_so", 32'(so4), 32'd1);
    pi4 = 4'h0; sel4 = 1'b1; #2;
    chk("midcycle_pi_ignored", 32'(so4), 32'd1);
    pi4 = 4'hE; sel4 = 1'b0; #1;
    chk("midcycle_sel_ignored", 32'(so4), 32'd1);

    // WIDTH=8, FILL=1 sweep: 5A LSB first, then FILL.
    step8(1'b1, 1'b0, 8'h00);
    chk("w8_reset_so", 32'(so8), 32'd0);
    w8 = 8'h5A;
    exp8 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    step8(1'b0, 1'b0, w8);
    chk("w8_load_so", 32'(so8), 32'(exp8[0]));
    for (int k = 1; k <= 10; k++) begin
      step8(1'b0, 1'b1, 8'h00);
      chk($sformatf("w8_shift%0d_so", k), 32'(so8), 32'(exp8[k]));
    end
    chk("w8_saturate_q", 32'(dut8.w_q), 32'hFF);

    // Random 4-bit: model register as a queue of pending bits, front = so.
    step4(1'b1, 1'b0, 4'h0);
    mq.delete();
    for (int k = 0; k < 4; k++) mq.push_back(1'b0);
    for (int i = 0; i < 300; i++) begin
      c = ($urandom_range(0, 15) == 0);
      s = 1'($urandom_range(0, 1));
      p = 8'($urandom);
      step4(c, s, p[3:0]);
      if (c) begin
        mq.delete();
        for (int k = 0; k < 4; k++) mq.push_back(1'b0);
      end else if (!s) begin
        mq.delete();
        for (int k = 0; k < 4; k++) mq.push_back(p[k]);
      end else begin
        void'(mq.pop_front());
        mq.push_back(1'b0);
      end
      chk($sformatf("rnd4_%0d", i), 32'(so4), 32'(mq[0]));
    end

    // Random 8-bit with FILL=1.
    step8(1'b1, 1'b0, 8'h00);
    mq.delete();
    for (int k = 0; k < 8; k++) mq.push_back(1'b0);
    for (int i = 0; i < 300; i++) begin
      c = ($urandom_range(0, 15) == 0);
      s = ($urandom_range(0, 3) != 0);
      p = 8'($urandom);
      step8(c, s, p);
      if (c) begin
        mq.delete();
        for (int k = 0; k < 8; k++) mq.push_back(1'b0);
      end else if (!s) begin
        mq.delete();
        for (int k = 0; k < 8; k++) mq.push_back(p[k]);
      end else begin
        void'(mq.pop_front());
        mq.push_back(1'b1);
      end
      chk($sformatf("rnd8_%0d", i), 32'(so8), 32'(mq[0]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
